// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: binary PRODUCT to packed BCD digits.
// One add-3/shift step per clock. A conversion starts on a rising edge of START.
//   CLK   : rising-edge clock
//   RESET : synchronous active-high reset
//   START : conversion request level; its rising edge is detected internally
//   BIN   : binary value, sampled only when a request is accepted
//   BUSY  : high while a conversion is running
//   VALID : one-cycle pulse when BCD/BLANK are updated
//   BCD   : packed BCD result, ones digit in [3:0]; held between conversions
//   BLANK : leading-zero flags per digit; bit 0 is always 0
module product_bcd_converter #(
  parameter int unsigned PW = 8,
  parameter int unsigned ND = 3,
  parameter int unsigned CW = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [PW-1:0]   BIN,
  output logic            BUSY,
  output logic            VALID,
  output logic [4*ND-1:0] BCD,
  output logic [ND-1:0]   BLANK
);

  localparam int unsigned BW = 4 * ND;
  // Every digit except the ones digit is blanked after reset.
  localparam logic [ND-1:0] BLANK_RST = ~ND'(1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            start_q, start_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   shift_q, shift_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [ND-1:0]   blank_q, blank_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;

  logic            start_req_c;
  logic [BW-1:0]   adj_c;
  logic [BW-1:0]   scratch_sh_c;
  logic [PW-1:0]   shift_sh_c;
  logic [ND-1:0]   blank_calc_c;
  logic            any_nz_c;

  assign start_req_c = START & ~start_q;

  // Next-state, datapath step and output computation.
  always_comb begin
    state_d      = state_q;
    start_d      = START;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    scratch_d    = scratch_q;
    bcd_d        = bcd_q;
    blank_d      = blank_q;
    busy_d       = busy_q;
    valid_d      = 1'b0;
    adj_c        = scratch_q;
    blank_calc_c = '0;
    any_nz_c     = 1'b0;

    // Add 3 to every digit >= 5 so the following shift carries correctly.
    for (int i = 0; i < int'(ND); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    {scratch_sh_c, shift_sh_c} = {adj_c, shift_q} << 1;

    // A digit is blanked only if it and every digit above it are zero.
    for (int i = int'(ND) - 1; i >= 1; i--) begin
      any_nz_c        = any_nz_c | (scratch_sh_c[4*i +: 4] != 4'd0);
      blank_calc_c[i] = ~any_nz_c;
    end

    unique case (state_q)
      IDLE: begin
        if (start_req_c) begin
          shift_d   = BIN;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = scratch_sh_c;
        shift_d   = shift_sh_c;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(PW - 1)) begin
          bcd_d   = scratch_sh_c;
          blank_d = blank_calc_c;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign BUSY  = busy_q;
  assign VALID = valid_q;
  assign BCD   = bcd_q;
  assign BLANK = blank_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench for product_bcd_converter: stimulus pushes expected results
// with their expected VALID cycle; a monitor pops and compares on each VALID.
module tb_product_bcd_converter;

  localparam int unsigned PW = 8;
  localparam int unsigned ND = 3;
  localparam int unsigned CW = 4;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            START;
  logic [PW-1:0]   BIN;
  logic            BUSY;
  logic            VALID;
  logic [4*ND-1:0] BCD;
  logic [ND-1:0]   BLANK;

  typedef struct {
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   blank;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_busy = 1'b0;

  product_bcd_converter #(.PW(PW), .ND(ND), .CW(CW)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .START(START),
    .BIN  (BIN),
    .BUSY (BUSY),
    .VALID(VALID),
    .BCD  (BCD),
    .BLANK(BLANK)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every VALID must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(VALID), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("bcd", 32'(BCD), 32'(e.bcd));
          check("blank", 32'(BLANK), 32'(e.blank));
          check("valid_cycle", 32'(cyc), 32'(e.cyc));
          check("busy_at_valid", 32'(BUSY), 32'(0));
          check("busy_before_valid", 32'(prev_busy), 32'(1));
        end
      end
      prev_busy = BUSY;
    end
  end

  // Raise START with BIN at a negedge; the next posedge accepts the request.
  task automatic issue(input logic [PW-1:0] bin, input logic [4*ND-1:0] bcd,
                       input logic [ND-1:0] blank);
    exp_t e;
    BIN   = bin;
    START = 1'b1;
    e.bcd = bcd; e.blank = blank; e.cyc = cyc + 1 + int'(PW);
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
  endtask

  task automatic run_conv(input logic [PW-1:0] bin, input logic [4*ND-1:0] bcd,
                          input logic [ND-1:0] blank);
    issue(bin, bcd, blank);
    START = 1'b0;
    wait_drain();
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    BIN   = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_valid", 32'(VALID), 32'(0));
    check("rst_bcd", 32'(BCD), 32'(0));
    check("rst_blank", 32'(BLANK), 32'(3'b110));
    RESET = 1'b0;
    @(negedge CLK);

    // Zero input; BUSY must stay high for exactly PW cycles.
    issue(8'h00, 12'h000, 3'b110);
    START = 1'b0;
    for (int i = 0; i < int'(PW); i++) begin
      check("busy_during_conv", 32'(BUSY), 32'(1));
      @(negedge CLK);
    end
    check("busy_after_conv", 32'(BUSY), 32'(0));
    wait_drain();
    @(negedge CLK);

    run_conv(8'hE1, 12'h225, 3'b000);
    run_conv(8'hFF, 12'h255, 3'b000);
    run_conv(8'h09, 12'h009, 3'b110);

    // START left high after completion must not retrigger.
    issue(8'h5A, 12'h090, 3'b100);
    wait_drain();
    BIN = 8'h10;
    repeat (15) @(negedge CLK);
    check("held_start_bcd", 32'(BCD), 32'(12'h090));
    check("held_start_busy", 32'(BUSY), 32'(0));
    START = 1'b0;
    @(negedge CLK);
    run_conv(8'h10, 12'h016, 3'b100);

    // A second START edge mid-conversion is ignored.
    issue(8'h64, 12'h100, 3'b000);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    START = 1'b1;
    BIN   = 8'h33;
    @(negedge CLK);
    START = 1'b0;
    wait_drain();
    repeat (12) @(negedge CLK);
    check("ignored_start_bcd", 32'(BCD), 32'(12'h100));

    // Reset mid-conversion discards it; held START restarts after release.
    BIN   = 8'hC8;
    START = 1'b1;
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("midrst_bcd", 32'(BCD), 32'(0));
    check("midrst_busy", 32'(BUSY), 32'(0));
    check("midrst_valid", 32'(VALID), 32'(0));
    check("midrst_blank", 32'(BLANK), 32'(3'b110));
    RESET = 1'b0;
    begin
      exp_t e;
      e.bcd = 12'h200; e.blank = 3'b000; e.cyc = cyc + 1 + int'(PW);
      exp_q.push_back(e);
    end
    @(negedge CLK);
    check("restart_busy", 32'(BUSY), 32'(1));
    wait_drain();
    START = 1'b0;
    repeat (12) @(negedge CLK);
    check("final_bcd", 32'(BCD), 32'(12'h200));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
- Downstream consumer of the unsigned shift-add multiplier.
- Takes the 2N-bit binary PRODUCT and converts it to packed BCD digits for the seven-segment display stage, using sequential double-dabble: one adjust-and-shift per clock.
- Conversion is triggered by the multiplier's DONE level, which is wired to START.
- Also provides leading-zero blanking flags for the display driver.

Parameters:
- PW, 8, binary input width (2N for the N=4 multiplier).
- ND, 3, number of BCD output digits. Must satisfy 10^ND > 2^PW-1; the default covers 0..255.
- CW, 4, iteration counter width. Must satisfy 2^CW > PW.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous reset, active-high.
- START  input  1  conversion request, level. A rising edge is detected internally (connect multiplier DONE).
- BIN  input  PW  binary value to convert (connect multiplier PRODUCT). Sampled only on an accepted start.
- BUSY  output  1  high while converting.
- VALID  output  1  one-cycle pulse when BCD/BLANK update.
- BCD  output  4*ND  packed BCD. Digit 0 (ones) is in bits [3:0]. Held between conversions.
- BLANK  output  ND  bit i=1 when digit i is a leading zero. Bit 0 is always 0.

Behaviour:
- Reset (RESET=1 at a CLK edge): state=IDLE, BUSY=0, VALID=0, BCD=0, BLANK={ND-1{1},0}, start_q=0, counter=0, scratch registers=0. Reset overrides all other activity, including an in-flight conversion, which is discarded.
- Edge detect:
  - start_q <= START every cycle.
  - start_req = START & ~start_q.
  - Because start_q resets to 0, a START held high across reset release produces exactly one request on the first non-reset edge.
- State IDLE:
  - On an edge with start_req=1: shift register <= BIN, BCD scratch <= 0, counter <= 0, BUSY <= 1, state -> CONV.
  - Otherwise hold. BCD and BLANK keep their last values.
- State CONV, each edge:
  - For every scratch digit >= 5, add 3 to it (mod 16 within the nibble).
  - Then shift {scratch, shift register} left by 1.
  - counter <= counter+1.
  - On the edge where counter == PW-1 (the PW-th shift): BCD <= final scratch, BLANK computed from the final digits, VALID <= 1, BUSY <= 0, state -> IDLE.
- BLANK rule: bit i (i>=1) = 1 iff digit i and all digits above it are 0.
- Latency: start_req sampled at edge E0; BCD/VALID update at edge E0+PW. VALID is high for exactly the one cycle after that edge and is deasserted at the next edge.
- START edges arriving while BUSY=1 are ignored, not queued. start_q still tracks START, so a level held high does not retrigger later.
- A start_req on the same edge that VALID is being set is ignored, because the state is still CONV on that edge. A start_req on the next edge (IDLE) is accepted. The minimum request spacing is therefore PW+1 cycles.
- BIN changes during CONV have no effect.
- No arithmetic overflow is possible when the parameter constraints hold. Behaviour outside those constraints is undefined and need not be checked.

Test Plan:
- Reset, then BIN=0x00, START 0->1 -> BUSY high 8 cycles. At E0+8: BCD=0x000, BLANK=3'b110, VALID one cycle.
- BIN=0xE1 (15*15=225), rising START -> BCD=0x225, BLANK=3'b000. BUSY deasserts on the same edge that VALID asserts.
- BIN=0xFF -> BCD=0x255. BIN=0x09 -> BCD=0x009, BLANK=3'b110. BIN=0x5A (90) -> BCD=0x090, BLANK=3'b100.
- START held high after a completed conversion, with BIN changed to 0x10 -> no second VALID, BCD remains the previous value. Drop START, re-raise it -> BCD=0x016.
- Second START pulse 3 cycles into a conversion of 0x64 -> ignored. Exactly one VALID occurs, with BCD=0x100 and BLANK=3'b000.
- RESET asserted 4 cycles into a conversion of 0xC8 with START held high -> BCD=0, BUSY=0, no VALID. After RESET is released, a conversion starts and completes with BCD=0x200 after 8 cycles.
